uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter peripheral on the data bus behind the MMU.
- The CPU writes bytes into a 4-entry TX FIFO. The block serialises them on o_Tx as 8N1 frames, LSB first.
- A status register exposes FIFO and line state so firmware can poll before writing.
- It is the transmit end of the serial link whose receive side samples i_Rx.

---
 rtl/uart_tx_mmio.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter fed by a small TX FIFO.
// address[3:2]: 0 = TXDATA (write-only), 1 = STATUS (read; any write clears overflow).
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] w_data,
  input  logic        we,
  output logic [31:0] r_data,
  output logic        o_Tx,
  output logic        o_busy
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic       sel_txdata, sel_status;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic       baud_last, tx_active;
  logic [7:0] head;
  logic [2:0] cnt3;
  logic       unused_bits;

  assign sel_txdata = we && (address[3:2] == 2'd0);
  assign sel_status = we && (address[3:2] == 2'd1);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx_active  = (state_q != S_IDLE);
  // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
  assign push       = sel_txdata && (!fifo_full || pop);
  assign cnt3        = 3'(count_q);
  assign unused_bits = ^{address[15:4], address[1:0], w_data[31:8]};

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (sel_txdata && fifo_full && !pop) ovf_d = 1'b1;
    else if (sel_status)                 ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Byte storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= w_data[7:0];
  end

  always_comb begin
    r_data = '0;
    if (address[3:2] == 2'd1) r_data[6:0] = {cnt3, ovf_q, tx_active, fifo_empty, fifo_full};
  end

  assign o_Tx   = tx_q;
  assign o_busy = tx_active | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: frame-level reference model compared every cycle,
// a line decoder, and hand-computed expectations for each directed scenario.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic [31:0] w_data = '0;
  logic        we = 1'b0;
  logic [31:0] r_data;
  logic        o_Tx;
  logic        o_busy;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .w_data(w_data), .we(we),
    .r_data(r_data), .o_Tx(o_Tx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: queued bytes plus the position inside the frame on the line.
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 1'b0;
  bit         m_pop;
  logic [7:0] m_popped;
  int         m_sz;

  // Line decoder state.
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  logic [9:0] fr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (address[3:2] == 2'd1) begin
      r[0]   = (mq.size() == DEPTH);
      r[1]   = (mq.size() == 0);
      r[2]   = m_act;
      r[3]   = m_ovf;
      r[6:4] = 3'(mq.size());
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz > 0) && (!m_act || m_pos == FRAME - 1);
      if (m_pop) m_popped = mq.pop_front();
      if (we && address[3:2] == 2'd0) begin
        if (m_sz < DEPTH || m_pop) mq.push_back(w_data[7:0]);
        else m_ovf = 1'b1;
      end else if (we && address[3:2] == 2'd1) begin
        m_ovf = 1'b0;
      end
      if (m_pop) begin
        m_act  = 1'b1;
        m_pos  = 0;
        m_byte = m_popped;
      end else if (m_act) begin
        if (m_pos == FRAME - 1) m_act = 1'b0;
        else m_pos++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("line", 32'(o_Tx), 32'(exp_tx()));
      chk("busy", 32'(o_busy), 32'(m_act || mq.size() > 0));
      chk("rdata", r_data, exp_rd());
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (chk_en && o_Tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_sh[rx_cnt / CPB - 1] = o_Tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        chk("stop_bit", 32'(o_Tx), 32'd1);
        rx_busy = 1'b0;
        rx_q.push_back(rx_sh);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address = a;
    w_data  = d;
    we      = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (o_busy && n < lim) begin
      step(1);
      n++;
    end
    chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic check_rx(input string nm, input int n, input logic [63:0] exp);
    chk({nm, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk({nm, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp[8*i +: 8]});
  endtask

  initial begin
    step(3);
    reset  = 1'b0;
    chk_en = 1'b1;

    address = 16'h4;
    #1;
    chk("reset_status", r_data, 32'h0000_0002);
    chk("reset_line", 32'(o_Tx), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_line", 32'(o_Tx), 32'd1);
      chk("idle_busy", 32'(o_busy), 32'd0);
    end
    address = 16'h8;
    #1;
    chk("reg2_read", r_data, 32'd0);
    address = 16'hC;
    #1;
    chk("reg3_read", r_data, 32'd0);
    wr(16'h8, 32'hFF);
    step(3);
    chk("reg2_write_ignored", 32'(o_busy), 32'd0);
    address = 16'h0;
    #1;
    chk("txdata_read", r_data, 32'd0);

    // Single 0xA5 frame, timed edge by edge.
    wr(16'h0, 32'hA5);
    chk("a5_line_k", 32'(o_Tx), 32'd1);
    chk("a5_busy_k", 32'(o_busy), 32'd1);
    fr = 10'b1_10100101_0;
    for (int j = 1; j <= FRAME; j++) begin
      step(1);
      chk("a5_line", 32'(o_Tx), 32'(fr[(j-1)/CPB]));
    end
    chk("a5_busy_k40", 32'(o_busy), 32'd1);
    step(1);
    chk("a5_busy_k41", 32'(o_busy), 32'd0);
    check_rx("a5", 1, 64'hA5);

    // Three queued bytes run as gapless frames.
    rx_q.delete();
    wr(16'h0, 32'h01);
    wr(16'h0, 32'h02);
    wr(16'h0, 32'h03);
    step(118);
    chk("b2b_busy_k120", 32'(o_busy), 32'd1);
    step(1);
    chk("b2b_busy_k121", 32'(o_busy), 32'd0);
    check_rx("b2b", 3, 64'h03_02_01);

    // Six writes in a row: one popped, four fill, the sixth overflows.
    rx_q.delete();
    for (int i = 0; i < 6; i++) wr(16'h0, 32'((i + 1) * 17));
    address = 16'h4;
    #1;
    chk("ovf_status", r_data, 32'h0000_004D);
    wr(16'h4, 32'h0);
    #1;
    chk("ovf_cleared_status", r_data, 32'h0000_0045);
    address = 16'h0;
    wait_idle(300);
    check_rx("ovf", 5, 64'h55_44_33_22_11);
    address = 16'h4;
    #1;
    chk("ovf_final_status", r_data, 32'h0000_0002);

    // Write into a full FIFO on the edge the stop bit ends and pops.
    rx_q.delete();
    for (int i = 0; i < 5; i++) wr(16'h0, 32'(8'hA1 + i));
    step(36);
    wr(16'h0, 32'hA6);
    address = 16'h4;
    #1;
    chk("fullpop_status", r_data, 32'h0000_0045);
    address = 16'h0;
    wait_idle(400);
    check_rx("fullpop", 6, 64'hA6_A5_A4_A3_A2_A1);

    // Reset during data bit 3 of 0x5A with two bytes queued.
    rx_q.delete();
    wr(16'h0, 32'h5A);
    wr(16'h0, 32'hB1);
    wr(16'h0, 32'hB2);
    step(16);
    reset = 1'b1;
    step(1);
    reset   = 1'b0;
    address = 16'h4;
    #1;
    chk("midreset_line", 32'(o_Tx), 32'd1);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_status", r_data, 32'h0000_0002);
    step(60);
    check_rx("after_reset", 0, 64'h0);
    rx_q.delete();
    wr(16'h0, 32'h3C);
    wait_idle(100);
    check_rx("post_reset", 1, 64'h3C);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
